// File: rtl/update_scheduler.sv
// Batch sequencer for execute_update: walks the model region in chunks, one op per chunk per
// sample, waiting for each op to finish before issuing the next.
module update_scheduler #(
  parameter int unsigned CNT_W = 32
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             start,
  input  logic [15:0]      cfg_model_offset,
  input  logic [15:0]      cfg_model_lines,
  input  logic [15:0]      cfg_chunk_lines,
  input  logic [CNT_W-1:0] cfg_num_samples,
  input  logic             cfg_forward_last,
  output logic             upd_op_start,
  output logic [31:0]      upd_regs0,
  output logic [31:0]      upd_regs1,
  input  logic             upd_op_done,
  output logic             busy,
  output logic             done,
  output logic             err,
  output logic [CNT_W-1:0] samples_done
);

  typedef enum logic [2:0] {StIdle, StCheck, StIssue, StWait, StAdvance, StDone} state_e;

  state_e           state_q, state_d;
  logic [15:0]      off_q, off_d;
  logic [15:0]      lines_q, lines_d;
  logic [15:0]      chunk_q, chunk_d;
  logic [CNT_W-1:0] nsamp_q, nsamp_d;
  logic             fwd_q, fwd_d;
  logic [15:0]      pos_q, pos_d;
  logic [CNT_W-1:0] sample_q, sample_d;
  logic [31:0]      regs0_q, regs0_d;
  logic [31:0]      regs1_q, regs1_d;
  logic             err_q, err_d;
  logic [CNT_W-1:0] samples_done_q, samples_done_d;

  logic             issue_load;
  logic [16:0]      range_end;
  logic [15:0]      pos_next;
  logic [15:0]      remaining;
  logic [15:0]      len;

  always_comb begin
    state_d        = state_q;
    off_d          = off_q;
    lines_d        = lines_q;
    chunk_d        = chunk_q;
    nsamp_d        = nsamp_q;
    fwd_d          = fwd_q;
    pos_d          = pos_q;
    sample_d       = sample_q;
    regs0_d        = regs0_q;
    regs1_d        = regs1_q;
    err_d          = err_q;
    samples_done_d = samples_done_q;
    issue_load     = 1'b0;
    range_end      = {1'b0, off_q} + {1'b0, lines_q};
    pos_next       = pos_q + regs0_q[31:16];
    remaining      = '0;
    len            = '0;

    unique case (state_q)
      StIdle: begin
        if (start) begin
          off_d          = cfg_model_offset;
          lines_d        = cfg_model_lines;
          chunk_d        = cfg_chunk_lines;
          nsamp_d        = cfg_num_samples;
          fwd_d          = cfg_forward_last;
          err_d          = 1'b0;
          samples_done_d = '0;
          state_d        = StCheck;
        end
      end
      StCheck: begin
        if (chunk_q == 16'd0 || range_end > 17'h10000) begin
          err_d   = 1'b1;
          state_d = StDone;
        end else if (nsamp_q == '0 || lines_q == 16'd0) begin
          state_d = StDone;
        end else begin
          pos_d      = '0;
          sample_d   = '0;
          issue_load = 1'b1;
          state_d    = StIssue;
        end
      end
      StIssue: state_d = StWait;
      StWait: begin
        if (upd_op_done) state_d = StAdvance;
      end
      StAdvance: begin
        if (pos_next == lines_q) begin
          pos_d          = '0;
          sample_d       = sample_q + CNT_W'(1);
          samples_done_d = samples_done_q + CNT_W'(1);
          if (sample_d == nsamp_q) begin
            state_d = StDone;
          end else begin
            issue_load = 1'b1;
            state_d    = StIssue;
          end
        end else begin
          pos_d      = pos_next;
          issue_load = 1'b1;
          state_d    = StIssue;
        end
      end
      StDone: state_d = StIdle;
      default: state_d = StIdle;
    endcase

    // Op registers are loaded on entry to ISSUE and held until the next ISSUE.
    if (issue_load) begin
      remaining = lines_q - pos_d;
      len       = (chunk_q < remaining) ? chunk_q : remaining;
      regs0_d   = {len, off_q + pos_d};
      regs1_d   = {31'b0, fwd_q && (sample_d == nsamp_q - CNT_W'(1))};
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q        <= StIdle;
      off_q          <= '0;
      lines_q        <= '0;
      chunk_q        <= '0;
      nsamp_q        <= '0;
      fwd_q          <= 1'b0;
      pos_q          <= '0;
      sample_q       <= '0;
      regs0_q        <= '0;
      regs1_q        <= '0;
      err_q          <= 1'b0;
      samples_done_q <= '0;
    end else begin
      state_q        <= state_d;
      off_q          <= off_d;
      lines_q        <= lines_d;
      chunk_q        <= chunk_d;
      nsamp_q        <= nsamp_d;
      fwd_q          <= fwd_d;
      pos_q          <= pos_d;
      sample_q       <= sample_d;
      regs0_q        <= regs0_d;
      regs1_q        <= regs1_d;
      err_q          <= err_d;
      samples_done_q <= samples_done_d;
    end
  end

  assign upd_op_start = (state_q == StIssue);
  assign busy         = (state_q != StIdle) && (state_q != StDone);
  assign done         = (state_q == StDone);
  assign upd_regs0    = regs0_q;
  assign upd_regs1    = regs1_q;
  assign err          = err_q;
  assign samples_done = samples_done_q;

endmodule

// File: tb/tb_update_scheduler.sv
// Scoreboard bench for update_scheduler: expected ops and batch results are queued by the
// stimulus and checked by a monitor when the DUT presents op_start or done.
module tb_update_scheduler;
  localparam int CNT_W = 32;

  logic             clk = 1'b0;
  logic             reset;
  logic             start;
  logic [15:0]      cfg_model_offset, cfg_model_lines, cfg_chunk_lines;
  logic [CNT_W-1:0] cfg_num_samples;
  logic             cfg_forward_last;
  logic             upd_op_start;
  logic [31:0]      upd_regs0, upd_regs1;
  logic             upd_op_done;
  logic             busy, done, err;
  logic [CNT_W-1:0] samples_done;
  logic             resp_done, spur_done;

  always #5 clk = ~clk;
  assign upd_op_done = resp_done | spur_done;

  update_scheduler #(.CNT_W(CNT_W)) dut (
    .clk              (clk),
    .reset            (reset),
    .start            (start),
    .cfg_model_offset (cfg_model_offset),
    .cfg_model_lines  (cfg_model_lines),
    .cfg_chunk_lines  (cfg_chunk_lines),
    .cfg_num_samples  (cfg_num_samples),
    .cfg_forward_last (cfg_forward_last),
    .upd_op_start     (upd_op_start),
    .upd_regs0        (upd_regs0),
    .upd_regs1        (upd_regs1),
    .upd_op_done      (upd_op_done),
    .busy             (busy),
    .done             (done),
    .err              (err),
    .samples_done     (samples_done)
  );

  int          n_checks = 0;
  int          n_pass   = 0;
  logic [63:0] exp_ops[$];   // {regs0, regs1}
  logic [32:0] exp_done[$];  // {err, samples_done}
  logic [63:0] mon_op;
  logic [32:0] mon_done;
  int          op_count = 0;
  int          resp_delay = 5;
  bit          resp_spur = 1'b0;
  bit          resp_abort;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
  endtask

  // Monitor
  always @(negedge clk) begin
    if (upd_op_start === 1'b1) begin
      op_count++;
      if (exp_ops.size() == 0) begin
        n_checks++;
        $display("FAIL unexpected_op: got regs0=0x%0h with no op expected", upd_regs0);
      end else begin
        mon_op = exp_ops.pop_front();
        check("op_regs0", 64'(upd_regs0), 64'(mon_op[63:32]));
        check("op_regs1", 64'(upd_regs1), 64'(mon_op[31:0]));
      end
    end
    if (done === 1'b1) begin
      check("done_busy_low", 64'(busy), 64'(0));
      if (exp_done.size() == 0) begin
        n_checks++;
        $display("FAIL unexpected_done: got done with err=%0b, none expected", err);
      end else begin
        mon_done = exp_done.pop_front();
        check("done_err", 64'(err), 64'(mon_done[32]));
        check("done_samples", 64'(samples_done), 64'(mon_done[31:0]));
      end
    end
  end

  // execute_update model: answers each op after resp_delay cycles, optionally with a
  // spurious pulse in the ISSUE cycle itself
  initial begin
    resp_done = 1'b0;
    forever begin
      @(negedge clk);
      if (upd_op_start === 1'b1 && !reset) begin
        resp_abort = 1'b0;
        if (resp_spur) resp_done = 1'b1;
        for (int i = 0; i < resp_delay; i++) begin
          @(negedge clk);
          resp_done = 1'b0;
          if (reset) resp_abort = 1'b1;
        end
        if (!resp_abort) begin
          resp_done = 1'b1;
          @(negedge clk);
          resp_done = 1'b0;
        end
      end
    end
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic set_cfg(input logic [15:0] off, input logic [15:0] lines,
                         input logic [15:0] chunk, input logic [CNT_W-1:0] ns, input logic fwd);
    cfg_model_offset = off;
    cfg_model_lines  = lines;
    cfg_chunk_lines  = chunk;
    cfg_num_samples  = ns;
    cfg_forward_last = fwd;
  endtask

  task automatic pulse_start();
    @(posedge clk); #1 start = 1'b1;
    @(posedge clk); #1 start = 1'b0;
  endtask

  task automatic wait_done(input string name, input int max, output int cyc);
    cyc = 0;
    while (1) begin
      @(negedge clk);
      cyc++;
      if (done === 1'b1) break;
      if (cyc >= max) begin
        n_checks++;
        $display("FAIL %s_timeout: got no done within %0d cycles, required done", name, max);
        break;
      end
    end
  endtask

  task automatic push_s1();
    for (int s = 0; s < 2; s++) begin
      exp_ops.push_back({32'h0010_0010, 32'(s)});
      exp_ops.push_back({32'h0010_0020, 32'(s)});
      exp_ops.push_back({32'h0008_0030, 32'(s)});
    end
    exp_done.push_back({1'b0, 32'd2});
  endtask

  task automatic end_check(input string name);
    @(posedge clk);
    check(name, 64'(exp_ops.size() + exp_done.size()), 64'(0));
  endtask

  int cyc;
  int base;

  initial begin
    reset = 1'b1; start = 1'b0; spur_done = 1'b0;
    set_cfg(16'h0, 16'h0, 16'h0, '0, 1'b0);
    repeat (3) @(posedge clk);
    #1 reset = 1'b0;
    @(negedge clk);
    check("rst_busy", 64'(busy), 64'(0));
    check("rst_done", 64'(done), 64'(0));
    check("rst_err", 64'(err), 64'(0));
    check("rst_op_start", 64'(upd_op_start), 64'(0));
    check("rst_regs0", 64'(upd_regs0), 64'(0));
    check("rst_regs1", 64'(upd_regs1), 64'(0));
    check("rst_samples", 64'(samples_done), 64'(0));

    // 1: three chunks per sample, two samples, forward on last sample
    set_cfg(16'h0010, 16'd40, 16'd16, 32'd2, 1'b1);
    push_s1();
    base = op_count;
    pulse_start();
    @(negedge clk);
    check("s1_busy", 64'(busy), 64'(1));
    wait_done("s1", 400, cyc);
    end_check("s1_queues_empty");
    check("s1_op_count", 64'(op_count - base), 64'(6));

    // 2: single short chunk, op_done the cycle right after ISSUE
    resp_delay = 1;
    set_cfg(16'h0000, 16'd16, 16'd64, 32'd1, 1'b0);
    exp_ops.push_back({32'h0010_0000, 32'd0});
    exp_done.push_back({1'b0, 32'd1});
    pulse_start();
    wait_done("s2", 100, cyc);
    end_check("s2_queues_empty");

    // boundary: offset+lines exactly 65536 is accepted
    set_cfg(16'hFFF0, 16'h0010, 16'd16, 32'd1, 1'b1);
    exp_ops.push_back({32'h0010_FFF0, 32'd1});
    exp_done.push_back({1'b0, 32'd1});
    pulse_start();
    wait_done("s2b", 100, cyc);
    end_check("s2b_queues_empty");
    resp_delay = 5;

    // 3: rejected configs
    set_cfg(16'h0010, 16'd40, 16'd0, 32'd2, 1'b0);
    exp_done.push_back({1'b1, 32'd0});
    pulse_start();
    wait_done("s3a", 20, cyc);
    check("s3a_latency", 64'(cyc), 64'(2));
    end_check("s3a_queues_empty");

    set_cfg(16'hFFF0, 16'h0020, 16'd16, 32'd1, 1'b0);
    exp_done.push_back({1'b1, 32'd0});
    pulse_start();
    wait_done("s3b", 20, cyc);
    check("s3b_latency", 64'(cyc), 64'(2));
    end_check("s3b_queues_empty");
    check("s3b_err_held", 64'(err), 64'(1));

    // 4: zero samples, no ops
    set_cfg(16'h0010, 16'd40, 16'd16, 32'd0, 1'b0);
    exp_done.push_back({1'b0, 32'd0});
    pulse_start();
    wait_done("s4", 20, cyc);
    end_check("s4_queues_empty");
    check("s4_err_cleared", 64'(err), 64'(0));

    // 5: spurious op_done in IDLE and ISSUE, stray starts mid-batch
    @(posedge clk); #1 spur_done = 1'b1;
    @(posedge clk); #1 spur_done = 1'b0;
    resp_spur = 1'b1;
    set_cfg(16'h0010, 16'd40, 16'd16, 32'd2, 1'b1);
    push_s1();
    base = op_count;
    pulse_start();
    repeat (6) @(posedge clk);
    #1 set_cfg(16'h0100, 16'd8, 16'd0, 32'd9, 1'b0);
    start = 1'b1;
    @(posedge clk); #1 start = 1'b0;
    repeat (13) @(posedge clk);
    #1 start = 1'b1;
    @(posedge clk); #1 start = 1'b0;
    set_cfg(16'h0010, 16'd40, 16'd16, 32'd2, 1'b1);
    wait_done("s5", 400, cyc);
    end_check("s5_queues_empty");
    check("s5_op_count", 64'(op_count - base), 64'(6));
    resp_spur = 1'b0;

    // 6: reset during WAIT of the second op, then a clean rerun
    resp_delay = 8;
    push_s1();
    base = op_count;
    pulse_start();
    cyc = 0;
    while (op_count - base < 2 && cyc < 200) begin
      @(negedge clk);
      cyc++;
    end
    check("s6_second_op_seen", 64'(op_count - base), 64'(2));
    @(posedge clk); #1 reset = 1'b1;
    @(posedge clk); #1 reset = 1'b0;
    exp_ops.delete();
    exp_done.delete();
    @(negedge clk);
    check("s6_busy", 64'(busy), 64'(0));
    check("s6_op_start", 64'(upd_op_start), 64'(0));
    check("s6_regs0", 64'(upd_regs0), 64'(0));
    check("s6_regs1", 64'(upd_regs1), 64'(0));
    repeat (12) @(negedge clk);
    check("s6_no_op_after_reset", 64'(op_count - base), 64'(2));
    resp_delay = 5;
    push_s1();
    base = op_count;
    pulse_start();
    wait_done("s6", 400, cyc);
    end_check("s6_queues_empty");
    check("s6_op_count", 64'(op_count - base), 64'(6));

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
